// File: rtl/ps_mailbox_reader_pkg.sv
// ps_mailbox_reader_pkg: shared types and ack-word layout for the PS mailbox reader.
package ps_mailbox_reader_pkg;
  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;
  typedef enum logic [2:0] {IDLE, RD_HDR, CHK, RD_PAY, HOLD, ACK} mbox_state_t;
  typedef struct packed {
    logic [15:0] seq;
    logic [15:0] len;
  } mbox_hdr_t;
  localparam int ACK_ERR_BIT = 31;
  localparam int ACK_SEQ_LSB = 0;
  function automatic logic [31:0] ack_word(logic err, logic [15:0] seq);
    logic [31:0] w;
    w = '0;
    w[ACK_ERR_BIT] = err;
    w[ACK_SEQ_LSB +: 16] = seq;
    return w;
  endfunction
endpackage

// File: rtl/ps_mailbox_reader_if.sv
// ps_mailbox_reader_if: BRAM port plus payload valid/ready stream of the mailbox reader.
interface ps_mailbox_reader_if;
  logic        mem_en_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_din_o;
  logic [31:0] mem_dout_i;
  logic [31:0] data_o;
  logic        valid_o;
  logic        last_o;
  logic        ready_i;
  modport master (
    output mem_en_o, mem_we_o, mem_addr_o, mem_din_o, data_o, valid_o, last_o,
    input  mem_dout_i, ready_i
  );
  modport slave (
    input  mem_en_o, mem_we_o, mem_addr_o, mem_din_o, data_o, valid_o, last_o,
    output mem_dout_i, ready_i
  );
endinterface

// File: rtl/ps_mailbox_reader_rd_pipe.sv
// ps_mailbox_reader_rd_pipe: tracks one BRAM read through RD_LATENCY cycles and strobes when dout is valid.
module ps_mailbox_reader_rd_pipe #(
  parameter int RD_LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic strobe_o,
  output logic pend_o
);
  logic [RD_LATENCY-1:0] sr_q;
  always_ff @(posedge clk) begin
    if (rst) sr_q <= '0;
    else sr_q <= (sr_q << 1) | RD_LATENCY'(en_i);
  end
  assign strobe_o = sr_q[RD_LATENCY-1];
  assign pend_o   = |sr_q;
endmodule

// File: rtl/ps_mailbox_reader.sv
// ps_mailbox_reader: polls a PS mailbox header, streams new payloads over valid/ready and writes back an ack word.
module ps_mailbox_reader
  import ps_mailbox_reader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int          MAX_WORDS     = 64,
  parameter int          RD_LATENCY    = 2,
  parameter int          POLL_INTERVAL = 1000
) (
  input  ckrs_t                       ClkRs_ix,
  input  logic                        enable_i,
  ps_mailbox_reader_if.master         mb,
  output logic                        busy_o,
  output logic                        err_o,
  output logic [15:0]                 msg_count_o
);
  localparam logic [31:0] ACK_ADDR = BASE_ADDR + 32'(4 * (MAX_WORDS + 1));
  logic clk, rst;
  assign clk = ClkRs_ix.clk;
  assign rst = ClkRs_ix.reset;
  mbox_state_t st_q, st_d;
  mbox_hdr_t   hdr_q, hdr_d;
  logic [31:0] timer_q, timer_d, data_q, data_d;
  logic [15:0] last_seq_q, last_seq_d, k_q, k_d, cnt_q, cnt_d;
  logic        valid_q, valid_d, last_q, last_d, err_q, err_d, ack_err_q, ack_err_d;
  logic        rd_en, strobe, pend;
  ps_mailbox_reader_rd_pipe #(.RD_LATENCY(RD_LATENCY)) u_pipe (
    .clk(clk), .rst(rst), .en_i(rd_en), .strobe_o(strobe), .pend_o(pend)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= IDLE;
      hdr_q      <= '0;
      timer_q    <= '0;
      data_q     <= '0;
      last_seq_q <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      ack_err_q  <= 1'b0;
    end else begin
      st_q       <= st_d;
      hdr_q      <= hdr_d;
      timer_q    <= timer_d;
      data_q     <= data_d;
      last_seq_q <= last_seq_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      err_q      <= err_d;
      ack_err_q  <= ack_err_d;
    end
  end
  always_comb begin
    st_d       = st_q;
    hdr_d      = hdr_q;
    timer_d    = timer_q;
    data_d     = data_q;
    last_seq_d = last_seq_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    last_d     = last_q;
    err_d      = err_q;
    ack_err_d  = ack_err_q;
    rd_en      = 1'b0;
    case (st_q)
      IDLE: begin
        if (!enable_i) timer_d = '0;
        else if (timer_q == 32'(POLL_INTERVAL - 1)) begin
          timer_d = '0;
          rd_en   = 1'b1;
          st_d    = RD_HDR;
        end else timer_d = timer_q + 32'd1;
      end
      RD_HDR: begin
        if (strobe) begin
          hdr_d = mb.mem_dout_i;
          st_d  = CHK;
        end
      end
      CHK: begin
        if (hdr_q.seq == last_seq_q || hdr_q.len == 16'd0) st_d = IDLE;
        else if (32'(hdr_q.len) > MAX_WORDS) begin
          err_d     = 1'b1;
          ack_err_d = 1'b1;
          st_d      = ACK;
        end else begin
          ack_err_d = 1'b0;
          k_d       = '0;
          st_d      = RD_PAY;
        end
      end
      RD_PAY: begin
        rd_en = !pend;
        if (strobe) begin
          data_d  = mb.mem_dout_i;
          valid_d = 1'b1;
          last_d  = k_q == hdr_q.len - 16'd1;
          st_d    = HOLD;
        end
      end
      HOLD: begin
        if (mb.ready_i) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          k_d     = last_q ? k_q : k_q + 16'd1;
          st_d    = last_q ? ACK : RD_PAY;
        end
      end
      ACK: begin
        last_seq_d = hdr_q.seq;
        cnt_d      = cnt_q + 16'd1;
        st_d       = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end
  assign mb.mem_en_o   = rd_en | (st_q == ACK);
  assign mb.mem_we_o   = st_q == ACK ? 4'hF : 4'h0;
  assign mb.mem_addr_o = st_q == ACK ? ACK_ADDR :
                         st_q == RD_PAY ? BASE_ADDR + ((32'(k_q) + 32'd1) << 2) : BASE_ADDR;
  assign mb.mem_din_o  = st_q == ACK ? ack_word(ack_err_q, hdr_q.seq) : '0;
  assign mb.data_o     = data_q;
  assign mb.valid_o    = valid_q;
  assign mb.last_o     = last_q;
  assign busy_o        = st_q != IDLE;
  assign err_o         = err_q;
  assign msg_count_o   = cnt_q;
endmodule

// File: tb/tb_ps_mailbox_reader.sv
// tb_ps_mailbox_reader: randomized mailbox traffic checked against a message-level model of the PS protocol.
module tb_ps_mailbox_reader;
  import ps_mailbox_reader_pkg::*;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int MAXW = 64;
  localparam int RDL  = 2;
  localparam int POLL = 20;
  localparam logic [31:0] ACK_A = BASE + 32'(4 * (MAXW + 1));
  logic clk = 1'b0, rst = 1'b1, enable = 1'b1;
  ckrs_t ck;
  logic busy, err;
  logic [15:0] count;
  ps_mailbox_reader_if mb();
  assign ck.clk = clk;
  assign ck.reset = rst;
  always #5 clk = ~clk;
  ps_mailbox_reader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .RD_LATENCY(RDL), .POLL_INTERVAL(POLL)) dut (
    .ClkRs_ix(ck), .enable_i(enable), .mb(mb), .busy_o(busy), .err_o(err), .msg_count_o(count)
  );
  int n_vec = 0, n_err = 0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  logic [31:0] mem [128];
  logic [31:0] rpipe [RDL];
  function automatic int widx(logic [31:0] a);
    return int'((a - BASE) >> 2) & 127;
  endfunction
  always @(posedge clk) begin
    rpipe[0] <= mem[widx(mb.mem_addr_o)];
    for (int i = 1; i < RDL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mb.mem_dout_i = rpipe[RDL-1];
  int mode = 0, bp_left = 0;
  initial begin
    mb.ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (mode == 1) mb.ready_i = 1'($urandom_range(0, 1));
      else if (mode == 2 && bp_left > 0 && mb.valid_o) begin
        mb.ready_i = 1'b0;
        bp_left--;
      end else mb.ready_i = 1'b1;
    end
  end
  logic [31:0] got_words[$], wr_addr[$], wr_data[$];
  logic        got_last[$];
  int rd_cnt = 0, stall_rd = 0;
  logic pv = 1'b0, pr = 1'b0;
  logic [31:0] pd = '0;
  always @(negedge clk) begin
    if (rst) pv <= 1'b0;
    else begin
      if (mb.valid_o && mb.ready_i) begin
        got_words.push_back(mb.data_o);
        got_last.push_back(mb.last_o);
      end
      if (mb.mem_en_o && mb.mem_we_o == 4'hF) begin
        wr_addr.push_back(mb.mem_addr_o);
        wr_data.push_back(mb.mem_din_o);
      end
      if (mb.mem_en_o && mb.mem_we_o == 4'h0) rd_cnt <= rd_cnt + 1;
      if (mb.mem_en_o && mb.valid_o && !mb.ready_i) stall_rd <= stall_rd + 1;
      if (pv && !pr) begin
        chk("hold_valid", 32'(mb.valid_o), 32'd1);
        chk("hold_data", mb.data_o, pd);
      end
      pv <= mb.valid_o;
      pr <= mb.ready_i;
      pd <= mb.data_o;
    end
  end
  // Message-level model: what the PS expects to see for each header it posts
  logic [15:0] m_last = '0, m_count = '0;
  logic        m_err = 1'b0;
  logic [31:0] exp_words[$];
  logic [31:0] exp_ack;
  int stall_base;
  task automatic load(logic [15:0] seq, logic [15:0] len, bit fixed);
    logic [31:0] w;
    logic over;
    exp_words.delete();
    got_words.delete();
    got_last.delete();
    wr_addr.delete();
    wr_data.delete();
    stall_base = stall_rd;
    over = int'(len) > MAXW;
    for (int k = 0; k < int'(len) && k < MAXW; k++) begin
      w = fixed ? 32'hA0 + 32'(k) : $urandom;
      mem[k+1] = w;
      if (!over) exp_words.push_back(w);
    end
    mem[0] = {seq, len};
    if (seq != m_last && len != 16'd0) begin
      m_err |= over;
      exp_ack = {over, 15'b0, seq};
      m_last = seq;
      m_count++;
    end
  endtask
  task automatic await_msg();
    int c = 0;
    while (wr_data.size() == 0 && c < 4000) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    chk("n_words", got_words.size(), exp_words.size());
    foreach (exp_words[i]) begin
      if (i < got_words.size()) begin
        chk("word", got_words[i], exp_words[i]);
        chk("last", 32'(got_last[i]), 32'(i == exp_words.size() - 1));
      end
    end
    chk("wr_count", wr_data.size(), 1);
    if (wr_data.size() > 0) begin
      chk("ack_addr", wr_addr[0], ACK_A);
      chk("ack_data", wr_data[0], exp_ack);
    end
    chk("msg_count", 32'(count), 32'(m_count));
    chk("err", 32'(err), 32'(m_err));
    chk("busy", 32'(busy), 32'd0);
    chk("stall_reads", stall_rd - stall_base, 0);
  endtask
  task automatic idle_check(int n);
    got_words.delete();
    wr_data.delete();
    repeat (n) @(negedge clk);
    chk("idle_words", got_words.size(), 0);
    chk("idle_writes", wr_data.size(), 0);
    chk("idle_count", 32'(count), 32'(m_count));
  endtask
  task automatic check_reset_vals();
    chk("rst_valid", 32'(mb.valid_o), 0);
    chk("rst_last", 32'(mb.last_o), 0);
    chk("rst_data", mb.data_o, 0);
    chk("rst_en", 32'(mb.mem_en_o), 0);
    chk("rst_we", 32'(mb.mem_we_o), 0);
    chk("rst_addr", mb.mem_addr_o, BASE);
    chk("rst_din", mb.mem_din_o, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_count", 32'(count), 0);
  endtask
  initial begin
    int c, rd0;
    logic [15:0] s;
    foreach (mem[i]) mem[i] = '0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    load(16'd1, 16'd3, 1'b1);
    await_msg();
    idle_check(5 * POLL);
    mode = 2;
    bp_left = 7;
    load(16'd2, 16'd2, 1'b0);
    await_msg();
    mode = 0;
    load(16'd3, 16'd65, 1'b0);
    await_msg();
    load(16'd4, 16'd4, 1'b0);
    c = 0;
    while (got_words.size() < 2 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("words_before_reset", got_words.size(), 2);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    chk("no_ack_on_reset", wr_data.size(), 0);
    rst = 1'b0;
    m_last = '0;
    m_count = '0;
    m_err = 1'b0;
    load(16'd4, 16'd4, 1'b0);
    await_msg();
    load(16'd7, 16'd0, 1'b0);
    idle_check(3 * POLL);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    load(16'hFFFF, 16'd2, 1'b0);
    rd0 = rd_cnt;
    repeat (3 * POLL) @(negedge clk);
    chk("reads_disabled", rd_cnt - rd0, 0);
    enable = 1'b1;
    await_msg();
    load(16'h0000, 16'd3, 1'b0);
    await_msg();
    mode = 1;
    for (int i = 0; i < 6; i++) begin
      s = m_last + 16'($urandom_range(1, 3));
      load(s, i == 5 ? 16'(MAXW) : 16'($urandom_range(1, 8)), 1'b0);
      await_msg();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
